// File: rtl/register_serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// The bit timer advances only on enabled cycles; all outputs are registered.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | line high, ready for a word (also the one-cycle done slot)
// START | start bit (0) for DIVIDER enabled cycles
// DATA  | shift_reg[0] on the line, one bit per DIVIDER enabled cycles
// STOP  | stop bit (1) for DIVIDER enabled cycles
module register_serial_tx #(
    parameter int WIDTH   = 8,
    parameter int DIVIDER = 4
) (
    input  logic             clock,
    input  logic             input_clear_n,
    input  logic             input_clock_enable,
    input  logic [WIDTH-1:0] input_d,
    input  logic             input_valid,
    output logic             output_ready,
    output logic             output_serial,
    output logic             output_busy,
    output logic             output_done
);

    localparam int TW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(DIVIDER - 1);
    localparam logic [IW-1:0] BIT_LAST   = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [TW-1:0]    timer;
    logic [IW-1:0]    bit_idx;
    logic             timer_last;

    assign shift_next = shift_reg >> 1;
    assign timer_last = (timer == TIMER_LAST);

    always_ff @(posedge clock or negedge input_clear_n) begin
        if (!input_clear_n) begin
            state         <= IDLE;
            shift_reg     <= '0;
            timer         <= '0;
            bit_idx       <= '0;
            output_serial <= 1'b1;
            output_ready  <= 1'b1;
            output_busy   <= 1'b0;
            output_done   <= 1'b0;
        end else begin
            // done is a single enabled-edge pulse; a frozen cycle drops it
            output_done <= 1'b0;
            if (input_clock_enable) begin
                case (state)
                    IDLE: begin
                        if (input_valid && output_ready) begin
                            shift_reg     <= input_d;
                            timer         <= '0;
                            bit_idx       <= '0;
                            state         <= START;
                            output_serial <= 1'b0;
                            output_ready  <= 1'b0;
                            output_busy   <= 1'b1;
                        end
                    end
                    START: begin
                        if (timer_last) begin
                            timer         <= '0;
                            bit_idx       <= '0;
                            state         <= DATA;
                            output_serial <= shift_reg[0];
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    DATA: begin
                        if (timer_last) begin
                            timer     <= '0;
                            shift_reg <= shift_next;
                            if (bit_idx == BIT_LAST) begin
                                state         <= STOP;
                                output_serial <= 1'b1;
                            end else begin
                                bit_idx       <= bit_idx + IW'(1);
                                output_serial <= shift_next[0];
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    STOP: begin
                        if (timer_last) begin
                            timer         <= '0;
                            state         <= IDLE;
                            output_serial <= 1'b1;
                            output_ready  <= 1'b1;
                            output_busy   <= 1'b0;
                            output_done   <= 1'b1;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        timer         <= '0;
                        output_serial <= 1'b1;
                        output_ready  <= 1'b1;
                        output_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_register_serial_tx.sv
// Bench for register_serial_tx: stimulus pushes expected frames, a monitor
// checks the line cycle by cycle against them.
module tb_register_serial_tx;

    localparam int W        = 8;
    localparam int DIV      = 4;
    localparam int FRAME_EN = (W + 2) * DIV;

    logic         clock = 1'b0;
    logic         input_clear_n = 1'b0;
    logic         input_clock_enable = 1'b1;
    logic [W-1:0] input_d = '0;
    logic         input_valid = 1'b0;
    logic         output_ready;
    logic         output_serial;
    logic         output_busy;
    logic         output_done;

    register_serial_tx #(.WIDTH(W), .DIVIDER(DIV)) dut (
        .clock              (clock),
        .input_clear_n      (input_clear_n),
        .input_clock_enable (input_clock_enable),
        .input_d            (input_d),
        .input_valid        (input_valid),
        .output_ready       (output_ready),
        .output_serial      (output_serial),
        .output_busy        (output_busy),
        .output_done        (output_done)
    );

    always #5 clock = ~clock;

    // bits[i] is the i-th line bit of the frame, start bit first
    typedef struct {
        logic [9:0] bits;
        int         exp_cycles;
        bit         b2b;
        bit         abort_ok;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [9:0] bits, input int cyc, input bit b2b, input bit abort_ok);
        frame_t f;
        f.bits       = bits;
        f.exp_cycles = cyc;
        f.b2b        = b2b;
        f.abort_ok   = abort_ok;
        exp_q.push_back(f);
    endtask

    task automatic send(input logic [W-1:0] w);
        @(negedge clock);
        input_d            = w;
        input_valid        = 1'b1;
        input_clock_enable = 1'b1;
        @(negedge clock);
        input_valid = 1'b0;
    endtask

    // monitor state
    frame_t cur;
    bit     mon_active = 0;
    bit     prev_done  = 0;
    bit     ce_edge;
    int     en_cnt, cyc;
    logic   p_serial, p_ready, p_busy;

    initial begin : monitor
        forever begin
            @(posedge clock);
            ce_edge = input_clock_enable;
            #1;
            if (!input_clear_n) begin
                if (mon_active && !cur.abort_ok) begin
                    fails++;
                    $display("FAIL frame_aborted: got reset mid-frame expected complete frame");
                end
                mon_active = 0;
                prev_done  = 0;
            end else if (mon_active) begin
                cyc++;
                if (ce_edge) begin
                    en_cnt++;
                    if (en_cnt == FRAME_EN) begin
                        check("done_pulse", output_done, 1);
                        check("done_ready", output_ready, 1);
                        check("done_busy", output_busy, 0);
                        check("done_serial", output_serial, 1);
                        if (cur.exp_cycles != 0) check("frame_cycles", cyc, cur.exp_cycles);
                        mon_active = 0;
                        prev_done  = 1;
                    end else begin
                        check("frame_serial", output_serial, cur.bits[en_cnt / DIV]);
                        check("frame_busy", output_busy, 1);
                        check("frame_ready", output_ready, 0);
                        check("frame_done", output_done, 0);
                    end
                end else begin
                    check("hold_serial", output_serial, p_serial);
                    check("hold_busy", output_busy, p_busy);
                    check("hold_ready", output_ready, p_ready);
                    check("hold_done", output_done, 0);
                end
            end else if (output_busy) begin
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_frame: got frame start expected idle line");
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1;
                    en_cnt     = 0;
                    cyc        = 0;
                    check("start_serial", output_serial, cur.bits[0]);
                    check("start_ready", output_ready, 0);
                    check("start_done", output_done, 0);
                    if (cur.b2b) check("b2b_no_gap", prev_done, 1);
                end
                prev_done = 0;
            end else begin
                check("idle_serial", output_serial, 1);
                check("idle_ready", output_ready, 1);
                check("idle_done", output_done, 0);
                prev_done = 0;
            end
            p_serial = output_serial;
            p_ready  = output_ready;
            p_busy   = output_busy;
        end
    end

    initial begin : stimulus
        bit got_ready;

        // 1: reset held low for three cycles
        repeat (3) @(negedge clock);
        check("rst_serial", output_serial, 1);
        check("rst_ready", output_ready, 1);
        check("rst_busy", output_busy, 0);
        check("rst_done", output_done, 0);
        input_clear_n = 1'b1;
        repeat (3) @(negedge clock);

        // 2: 8'hA5 with CE always high
        push(10'b11_0100_1010, 40, 0, 0);
        send(8'hA5);
        input_d = 8'h00;
        repeat (45) @(negedge clock);

        // 3: 8'h3C with CE toggling after accept
        push(10'b10_0111_1000, 80, 0, 0);
        @(negedge clock);
        input_d            = 8'h3C;
        input_valid        = 1'b1;
        input_clock_enable = 1'b1;
        @(negedge clock);
        input_valid        = 1'b0;
        input_clock_enable = 1'b0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clock);
            input_clock_enable = ~input_clock_enable;
        end
        input_clock_enable = 1'b1;
        repeat (4) @(negedge clock);

        // 4: 8'hFF frame with ignored valid pulses of 8'h00
        push(10'b11_1111_1110, 40, 0, 0);
        send(8'hFF);
        repeat (8) @(negedge clock);
        input_d     = 8'h00;
        input_valid = 1'b1;
        @(negedge clock);
        input_valid = 1'b0;
        repeat (15) @(negedge clock);
        input_valid = 1'b1;
        @(negedge clock);
        input_valid = 1'b0;
        repeat (20) @(negedge clock);

        // 5: 8'h81 aborted by async reset, then a clean 8'h42
        push(10'b11_0000_0010, 0, 0, 1);
        send(8'h81);
        repeat (13) @(negedge clock);
        #2;
        input_clear_n = 1'b0;
        #1;
        check("abort_serial", output_serial, 1);
        check("abort_busy", output_busy, 0);
        check("abort_ready", output_ready, 1);
        check("abort_done", output_done, 0);
        repeat (2) @(negedge clock);
        input_clear_n = 1'b1;
        repeat (2) @(negedge clock);
        push(10'b10_1000_0100, 40, 0, 0);
        send(8'h42);
        repeat (45) @(negedge clock);

        // 6: valid held high, 8'h01 then 8'h80 back to back
        push(10'b10_0000_0010, 40, 0, 0);
        push(10'b11_0000_0000, 40, 1, 0);
        @(negedge clock);
        input_d     = 8'h01;
        input_valid = 1'b1;
        @(negedge clock);
        input_d = 8'h80;
        got_ready = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (output_ready) begin
                got_ready = 1;
                break;
            end
        end
        if (!got_ready) begin
            fails++;
            $display("FAIL b2b_ready_timeout: got no ready expected ready within 100 cycles");
        end
        @(negedge clock);
        input_valid = 1'b0;
        repeat (50) @(negedge clock);

        check("queue_empty", exp_q.size(), 0);
        check("monitor_idle", mon_active, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
